case_select_scheduler: RTL
==========================

// Module: case_select_scheduler
// PURPOSE
//  Round-robin scheduler sharing one combinational case-selection datapath
//  (8-bit number + 2-bit select -> 8-bit result) among 4 requesters.
//  Grants one requester at a time, drives select/number to the datapath,
//  registers its result, and returns it with a valid/ready handshake.
//  Sits between requester counters and the shared case_no_full datapath.
// PARAMETERS
//  DATA_W   8   width of number/result buses
//  N_REQ    4   requester count; fixed at 4 (select is 2 bits)
// PORTS
//  clk         in   1        single system clock, rising edge
//  Reset       in   1        asynchronous, active-high reset
//  req         in   N_REQ    per-requester request level, held until grant
//  number_in   in   N_REQ*DATA_W  packed operands, req i at [i*DATA_W +: DATA_W]
//  grant       out  N_REQ    one-hot, 1-cycle pulse when request accepted
//  sel         out  2        select to datapath (index of granted requester)
//  number_out  out  DATA_W   operand to datapath, registered at grant
//  result_in   in   DATA_W   combinational result from datapath
//  res_valid   out  1        result available
//  res_ready   in   1        consumer accepts result
//  res_id      out  2        requester index of current result
//  res_data    out  DATA_W   registered result
//  busy        out  1        high in any state except IDLE
//  issue_cnt   out  8        completed-transaction count (see CONFIGURATION)
//  OV          out  1        issue_cnt wrap pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0; grant=0, sel=0, number_out=0, res_valid=0,
//   res_id=0, res_data=0, busy=0, issue_cnt=0, OV=0. Reset mid-transaction
//   aborts immediately; the pending result is discarded.
//  FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//   IDLE: if |req, select first set req at/after rr_ptr (wrap 3->0);
//    pulse grant[i], load sel=i and number_out=number_in[i]; go ISSUE.
//    If no req, stay IDLE with outputs held.
//   ISSUE: one settle cycle with sel/number_out stable; go CAPTURE.
//   CAPTURE: res_data<=result_in, res_id<=sel, res_valid<=1; go RESP.
//   RESP: hold res_valid/res_data/res_id stable until res_valid&&res_ready;
//    on that edge res_valid<=0, rr_ptr<=res_id+1 (mod 4); go IDLE.
//  Latency: grant edge -> res_valid 2 cycles later; minimum 4 cycles
//   per transaction (ready tied high); next grant possible the cycle
//   after handshake.
//  Round-robin: granted requester has lowest priority next arbitration;
//   no requester waits more than 3 other transactions.
//  req changes outside IDLE are ignored; number_in is sampled only at grant.
//  sel and number_out are held after the transaction until the next grant.
// CONFIGURATION
//  Macro ISSUE_CNT_EN:
//   defined: issue_cnt increments (mod 256) on each RESP handshake; OV is
//    high for exactly one cycle after issue_cnt wraps 8'hFF -> 8'h00.
//   undefined: no counter logic; issue_cnt tied 8'h00, OV tied 0.
//    Ports remain present.
// STRUCTURE
//  Package case_sched_pkg: DATA_W, N_REQ, SEL_W=2 constants; state enum
//   {IDLE, ISSUE, CAPTURE, RESP}.
//  Sub-module rr_arbiter_4: combinational req[3:0] + rr_ptr[1:0] ->
//   one-hot grant + 2-bit index. FSM, registers and counter stay in top.
// TESTING
//  1 Single req=4'b0010, number_in[15:8]=8'h5A -> grant=0010 for 1 cycle,
//    sel=1, number_out=5A; res_valid 2 cycles later, res_id=1,
//    res_data=datapath(5A,1).
//  2 req=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0; one grant
//    every 4 cycles.
//  3 res_ready=0 for 10 cycles in RESP -> res_valid, res_data, res_id
//    stable, no new grant; ready=1 -> handshake, IDLE next cycle.
//  4 Reset asserted during CAPTURE -> all outputs 0 asynchronously; after
//    release with req=4'b1000 -> first grant to 3 (rr_ptr=0 search).
//  5 ISSUE_CNT_EN: 256 back-to-back transactions -> issue_cnt 8'hFF -> 8'h00,
//    OV 1 cycle. Without the macro: issue_cnt=0, OV=0 throughout.

Source files
------------

// File: rtl/case_sched_pkg.sv
// Shared constants and FSM state type for the round-robin case-select scheduler.
package case_sched_pkg;
   localparam int DATA_W = 8;
   localparam int N_REQ  = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin pick: first set request at/after i_ptr.
module rr_arbiter_4
   import case_sched_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [SEL_W-1:0] o_idx
);

   logic             w_found;
   logic [SEL_W-1:0] w_j;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = i_ptr + SEL_W'(k);
         if (!w_found && i_req[w_j]) begin
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/case_select_scheduler.sv
// Shares one case-select datapath among 4 requesters, round-robin.
// Optional completed-transaction counter enabled by macro ISSUE_CNT_EN.
module case_select_scheduler
   import case_sched_pkg::*;
(
   input  logic                    clk,
   input  logic                    Reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] number_in,
   output logic [N_REQ-1:0]        grant,
   output logic [SEL_W-1:0]        sel,
   output logic [DATA_W-1:0]       number_out,
   input  logic [DATA_W-1:0]       result_in,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [SEL_W-1:0]        res_id,
   output logic [DATA_W-1:0]       res_data,
   output logic                    busy,
   output logic [7:0]              issue_cnt,
   output logic                    OV
);

   state_t            r_state;
   logic [SEL_W-1:0]  r_rr_ptr;
   logic [N_REQ-1:0]  r_grant;
   logic [SEL_W-1:0]  r_sel;
   logic [DATA_W-1:0] r_num;
   logic              r_res_valid;
   logic [SEL_W-1:0]  r_res_id;
   logic [DATA_W-1:0] r_res_data;

   logic [N_REQ-1:0]  w_gnt;
   logic [SEL_W-1:0]  w_idx;
   logic              w_hs;

   rr_arbiter_4 u_arb (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_gnt),
      .o_idx   (w_idx)
   );

   assign w_hs = (r_state == RESP) && r_res_valid && res_ready;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_sel       <= '0;
         r_num       <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_data  <= '0;
      end else begin
         r_grant <= '0;
         unique case (r_state)
            IDLE: begin
               if (|req) begin
                  r_grant <= w_gnt;
                  r_sel   <= w_idx;
                  r_num   <= number_in[w_idx*DATA_W +: DATA_W];
                  r_state <= ISSUE;
               end
            end
            ISSUE: r_state <= CAPTURE;
            CAPTURE: begin
               r_res_data  <= result_in;
               r_res_id    <= r_sel;
               r_res_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (w_hs) begin
                  r_res_valid <= 1'b0;
                  r_rr_ptr    <= r_res_id + 2'd1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant      = r_grant;
   assign sel        = r_sel;
   assign number_out = r_num;
   assign res_valid  = r_res_valid;
   assign res_id     = r_res_id;
   assign res_data   = r_res_data;
   assign busy       = (r_state != IDLE);

`ifdef ISSUE_CNT_EN
   logic [7:0] r_cnt;
   logic       r_ov;

   // OV marks the handshake that rolled the count over to zero
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_cnt <= '0;
         r_ov  <= 1'b0;
      end else begin
         r_ov <= 1'b0;
         if (w_hs) begin
            r_cnt <= r_cnt + 8'd1;
            r_ov  <= (r_cnt == 8'hFF);
         end
      end
   end

   assign issue_cnt = r_cnt;
   assign OV        = r_ov;
`else
   assign issue_cnt = 8'h00;
   assign OV        = 1'b0;
`endif

endmodule
